transmitter: RTL
================

TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1, clock cycles per serial bit (legal >= 1).
REQ-002 Parameter DATA_BITS, default 8, payload bits per frame.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-005 tx_start  input  1  request to send tx_data; accepted only on a cycle where tx_ready=1.
REQ-006 tx_data  input  DATA_BITS  byte to send, captured on the accepting edge.
REQ-007 tx_ready  output  1  high when the one-entry holding buffer is empty.
REQ-008 TXD  output  1  serial line, idle high.
REQ-009 tx_busy  output  1  high while any frame bit (start, data, stop) is on TXD.
REQ-010 tx_done  output  1  one-cycle pulse on the last cycle of each stop bit.

Function
REQ-011 Frame format SHALL be 8N1-style: one start bit (0), DATA_BITS data bits LSB first, one stop bit (1), no parity.
REQ-012 Each bit SHALL be held on TXD for exactly CLKS_PER_BIT cycles; frame length = (DATA_BITS+2)*CLKS_PER_BIT cycles.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP; IDLE->START on buffer-valid, START->DATA after one bit time, DATA->STOP after bit index DATA_BITS-1 completes, STOP->START if buffer valid else STOP->IDLE.
REQ-014 Acceptance (tx_start=1 and tx_ready=1 at an edge) SHALL write tx_data into the holding buffer; tx_start while tx_ready=0 SHALL be ignored (no overwrite, no error).
REQ-015 From IDLE, the accepting edge SHALL also move the FSM to START so TXD=0 is visible the cycle immediately after acceptance (latency 1 cycle); the buffer transfers to the shift register and tx_ready stays 1.
REQ-016 While a frame is in progress, one further byte MAY be accepted; tx_ready SHALL then be 0 until that byte moves to the shift register at the STOP->START transition.
REQ-017 Back-to-back frames SHALL have no idle gap: start bit of frame N+1 begins the cycle after the last stop-bit cycle of frame N.
REQ-018 Acceptance on the same edge as the STOP->START transfer SHALL be honoured: the buffered byte is transmitted, the new byte occupies the buffer, tx_ready=0.
REQ-019 tx_busy SHALL be 1 in START, DATA, STOP and 0 in IDLE; tx_done SHALL pulse even when a next frame follows.
REQ-020 Baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide (min 1), wrap to 0 at CLKS_PER_BIT-1; bit index SHALL be $clog2(DATA_BITS) bits wide.
REQ-021 TXD SHALL be registered (glitch-free, no combinational path from inputs).

Reset
REQ-022 reset=0 at a rising edge SHALL force: state IDLE, TXD=1, tx_busy=0, tx_done=0, tx_ready=1, buffer invalid, counters 0.
REQ-023 Reset mid-frame SHALL abort the frame immediately (TXD=1 the next cycle); the partial frame and any buffered byte SHALL be discarded.
REQ-024 tx_start asserted during reset SHALL be ignored.

Structure
REQ-025 Frame constants (START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1) and the FSM state encoding SHALL live in a shared uart_pkg used by both transmitter and receiver.
REQ-026 A sub-module baud_counter (enable, CLKS_PER_BIT parameter, bit_tick output) SHALL generate bit-time ticks and be reusable by the receiver.

Verification
REQ-027 Single byte, CLKS_PER_BIT=1: tx_data=8'hAA accepted at cycle 0 -> TXD cycles 1..10 = 0,0,1,0,1,0,1,0,1,1; tx_done at cycle 10; tx_busy 0 at cycle 11.
REQ-028 Loopback: TXD wired to receiver RXD, bytes 8'h00, 8'hFF, 8'h5A -> receiver recovers identical bytes, in order.
REQ-029 Back-to-back, CLKS_PER_BIT=4: 8'h55 then 8'hC3 accepted during first frame -> 80 consecutive busy cycles, start of frame 2 exactly 40 cycles after frame 1 start, tx_ready=0 from second acceptance until cycle 40.
REQ-030 Overrun: third tx_start while tx_ready=0 -> ignored; only the first two bytes appear on TXD.
REQ-031 Reset mid-frame: reset=0 during data bit 3 -> next cycle TXD=1, tx_busy=0, tx_ready=1; subsequent 8'h81 transmits a clean frame.
REQ-032 Boundary: tx_start on the final stop-bit cycle with buffer full -> buffered byte sent next, new byte held, tx_ready=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART frame constants and FSM state encoding.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/baud_counter.sv
// Bit-time tick generator; counts while enabled and
// pulses bit_tick on the last cycle of each bit.
module baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic bit_tick
);

  localparam int CW = cw(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  assign bit_tick = enable && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset || !enable || bit_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/transmitter.sv
// UART transmitter: start, LSB-first data, stop; one-entry
// holding buffer for gap-free back-to-back frames.
module transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 TXD,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int IW = cw(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  uart_state_e          r_state;
  uart_state_e          w_state_n;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_n;
  logic [DATA_BITS-1:0] r_buf;
  logic [DATA_BITS-1:0] w_buf_n;
  logic [IW-1:0]        r_idx;
  logic [IW-1:0]        w_idx_n;
  logic                 r_buf_valid;
  logic                 w_bv_n;
  logic                 r_txd;
  logic                 w_txd_n;
  logic                 w_tick;
  logic                 w_stop_end;
  logic                 w_ready;
  logic                 w_accept;

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .enable  (r_state != ST_IDLE),
    .bit_tick(w_tick)
  );

  // The buffer frees on the last stop cycle, so a start
  // there is accepted on the same edge as the transfer.
  assign w_stop_end = (r_state == ST_STOP) && w_tick;
  assign w_ready    = !r_buf_valid || w_stop_end;
  assign w_accept   = tx_start && w_ready;

  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_idx_n   = r_idx;
    w_buf_n   = r_buf;
    w_bv_n    = r_buf_valid;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_n = ST_START;
          w_shift_n = tx_data;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_n = ST_DATA;
          w_idx_n   = '0;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_n = r_shift >> 1;
          if (r_idx == LAST_IDX) begin
            w_state_n = ST_STOP;
          end else begin
            w_idx_n = r_idx + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_buf_valid) begin
            w_state_n = ST_START;
            w_shift_n = r_buf;
            w_bv_n    = 1'b0;
          end else if (w_accept) begin
            w_state_n = ST_START;
            w_shift_n = tx_data;
          end else begin
            w_state_n = ST_IDLE;
          end
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
    if (w_accept && (r_state != ST_IDLE) &&
        (r_buf_valid || !w_stop_end)) begin
      w_buf_n = tx_data;
      w_bv_n  = 1'b1;
    end
  end

  always_comb begin
    w_txd_n = IDLE_LEVEL;
    unique case (w_state_n)
      ST_START: w_txd_n = START_BIT;
      ST_DATA:  w_txd_n = w_shift_n[0];
      ST_STOP:  w_txd_n = STOP_BIT;
      default:  w_txd_n = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_idx       <= '0;
      r_buf       <= '0;
      r_buf_valid <= 1'b0;
      r_txd       <= IDLE_LEVEL;
    end else begin
      r_state     <= w_state_n;
      r_shift     <= w_shift_n;
      r_idx       <= w_idx_n;
      r_buf       <= w_buf_n;
      r_buf_valid <= w_bv_n;
      r_txd       <= w_txd_n;
    end
  end

  assign TXD      = r_txd;
  assign tx_busy  = (r_state != ST_IDLE);
  assign tx_done  = w_stop_end;
  assign tx_ready = w_ready;

endmodule
